// File: rtl/updi_pkg.sv
// updi_pkg
//   Shared types and constants for the UPDI timing blocks.
//   - updi_brk_state_t : break-sequencer FSM state encoding
//   - UPDI_BREAK_CLKS  : default break length in clocks
//   - max_int          : helper for sizing counters from several lengths
package updi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_DELIM,
    ST_GUARD
  } updi_brk_state_t;

  localparam int UPDI_BREAK_CLKS = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/updi_phase_timer.sv
// updi_phase_timer
//   Down-counter used to time a single phase. Loading len-1 on phase entry
//   makes the phase last exactly len cycles: zero_o rises in the last cycle.
// Ports
//   clk_i       in  system clock
//   rst_i       in  synchronous reset, active-high (counter -> 0)
//   load_i      in  load load_val_i on the next edge (wins over counting)
//   load_val_i  in  W bits, phase length minus one
//   zero_o      out counter is at zero (phase ends at this cycle's edge)
module updi_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so the counter can free-run while its owner is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/updi_break_seq.sv
// updi_break_seq
//   UPDI break-sequence generator: drives the line low for nb break periods
//   separated by high delimiters, then an optional high guard time.
// Ports
//   clk_i       in  system clock
//   rst_i       in  synchronous reset, active-high
//   start_i     in  request a sequence (only honoured while idle)
//   n_breaks_i  in  NB_W bits, break count latched on accepted start
//   abort_i     in  terminate a running sequence
//   busy_o      out sequence in progress, line owned by this block
//   pulse_o     out UPDI line level (0 = break, 1 = idle/delimiter)
//   done_o      out one-cycle strobe on normal completion
//   aborted_o   out one-cycle strobe on abort completion
module updi_break_seq
  import updi_pkg::*;
#(
  parameter int BREAK_CLKS = UPDI_BREAK_CLKS,
  parameter int DELIM_CLKS = 100,
  parameter int GUARD_CLKS = 0,
  parameter int MAX_BREAKS = 2,
  parameter int NB_W       = $clog2(MAX_BREAKS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [NB_W-1:0] n_breaks_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            pulse_o,
  output logic            done_o,
  output logic            aborted_o
);

  localparam int LEN_MAX = max_int(max_int(BREAK_CLKS, DELIM_CLKS), max_int(GUARD_CLKS, 2));
  localparam int CW      = $clog2(LEN_MAX);

  localparam logic [CW-1:0]   BREAK_LD = CW'(BREAK_CLKS - 1);
  localparam logic [CW-1:0]   DELIM_LD = CW'(DELIM_CLKS - 1);
  localparam logic [CW-1:0]   GUARD_LD = CW'((GUARD_CLKS > 0) ? GUARD_CLKS - 1 : 0);
  localparam logic [NB_W-1:0] MAX_NB   = NB_W'(MAX_BREAKS);

  updi_brk_state_t state_q;
  logic            busy_q;
  logic            pulse_q;
  logic            done_q;
  logic            aborted_q;
  logic [NB_W-1:0] brk_cnt_q;
  logic [NB_W-1:0] brk_cnt_d;

  logic            start_ok;
  logic            brk_rem;
  logic [NB_W-1:0] nb_clamped;
  logic            phase_zero;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;

  // A request arriving in the done cycle still belongs to the finished run.
  assign start_ok = start_i && !abort_i && !done_q;

  always_comb begin
    nb_clamped = n_breaks_i;
    if (n_breaks_i == '0) begin
      nb_clamped = NB_W'(1);
    end else if (n_breaks_i > MAX_NB) begin
      nb_clamped = MAX_NB;
    end
  end

  // Count of breaks still owed once the current break finishes.
  assign brk_cnt_d = brk_cnt_q - NB_W'(1);
  assign brk_rem   = (brk_cnt_d != '0);

  // Timer reload mirrors the FSM transitions below; an abort reloads nothing.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          tmr_load = 1'b1;
          tmr_val  = BREAK_LD;
        end
      end
      ST_BREAK: begin
        if (!abort_i && phase_zero) begin
          if (brk_rem) begin
            tmr_load = 1'b1;
            tmr_val  = DELIM_LD;
          end else if (GUARD_CLKS > 0) begin
            tmr_load = 1'b1;
            tmr_val  = GUARD_LD;
          end
        end
      end
      ST_DELIM: begin
        if (!abort_i && phase_zero) begin
          tmr_load = 1'b1;
          tmr_val  = BREAK_LD;
        end
      end
      default: ;
    endcase
  end

  updi_phase_timer #(
    .W(CW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (phase_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      pulse_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      brk_cnt_q <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start_ok) begin
          state_q   <= ST_BREAK;
          busy_q    <= 1'b1;
          pulse_q   <= 1'b0;
          brk_cnt_q <= nb_clamped;
        end
      end else if (abort_i) begin
        // Abort beats any phase completion happening in the same cycle.
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        pulse_q   <= 1'b1;
        aborted_q <= 1'b1;
      end else if (phase_zero) begin
        case (state_q)
          ST_BREAK: begin
            brk_cnt_q <= brk_cnt_d;
            if (brk_rem) begin
              state_q <= ST_DELIM;
              pulse_q <= 1'b1;
            end else if (GUARD_CLKS > 0) begin
              state_q <= ST_GUARD;
              pulse_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              pulse_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
          ST_DELIM: begin
            state_q <= ST_BREAK;
            pulse_q <= 1'b0;
          end
          default: begin
            // ST_GUARD expiry
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pulse_q <= 1'b1;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy_o    = busy_q;
  assign pulse_o   = pulse_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;

endmodule

// File: tb/tb_updi_break_seq.sv
// tb_updi_break_seq
//   Directed bench for updi_break_seq. Main instance: BREAK=5, DELIM=3,
//   GUARD=0, MAX=2; a second instance adds GUARD=4. Line activity is
//   measured as run lengths of pulse while busy is high.
module tb_updi_break_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_m = 1'b0, start_g = 1'b0;
  logic [1:0] nb_m = '0, nb_g = '0;
  logic       abort_m = 1'b0;
  logic       abort_g = 1'b0;
  logic       busy_m, pulse_m, done_m, aborted_m;
  logic       busy_g, pulse_g, done_g, aborted_g;

  always #5 clk = ~clk;

  updi_break_seq #(
    .BREAK_CLKS(5), .DELIM_CLKS(3), .GUARD_CLKS(0), .MAX_BREAKS(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_m), .n_breaks_i(nb_m), .abort_i(abort_m),
    .busy_o(busy_m), .pulse_o(pulse_m), .done_o(done_m), .aborted_o(aborted_m)
  );

  updi_break_seq #(
    .BREAK_CLKS(5), .DELIM_CLKS(3), .GUARD_CLKS(4), .MAX_BREAKS(2)
  ) dut_g (
    .clk_i(clk), .rst_i(rst), .start_i(start_g), .n_breaks_i(nb_g), .abort_i(abort_g),
    .busy_o(busy_g), .pulse_o(pulse_g), .done_o(done_g), .aborted_o(aborted_g)
  );

  // Which instance the measuring task observes.
  logic sel = 1'b0;
  logic obs_busy, obs_pulse, obs_done, obs_aborted;
  assign obs_busy    = sel ? busy_g    : busy_m;
  assign obs_pulse   = sel ? pulse_g   : pulse_m;
  assign obs_done    = sel ? done_g    : done_m;
  assign obs_aborted = sel ? aborted_g : aborted_m;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last measured run.
  int m_busy, m_lows, m_lmin, m_lmax, m_highs, m_hmin, m_hmax, m_done, m_pend, m_abrt;

  task automatic close_run(input logic lvl, input int run);
    if (lvl == 1'b0) begin
      m_lows++;
      if (run < m_lmin) m_lmin = run;
      if (run > m_lmax) m_lmax = run;
    end else begin
      m_highs++;
      if (run < m_hmin) m_hmin = run;
      if (run > m_hmax) m_hmax = run;
    end
  endtask

  // Called on the first sample after the start edge; returns on the first
  // sample with busy low (the done/aborted cycle).
  task automatic measure();
    int   run;
    int   guard;
    logic lvl;
    m_busy = 0; m_lows = 0; m_highs = 0;
    m_lmin = 1000; m_lmax = 0; m_hmin = 1000; m_hmax = 0;
    run = 0; guard = 0; lvl = obs_pulse;
    while (obs_busy && guard < 200) begin
      m_busy++;
      if (obs_pulse == lvl) begin
        run++;
      end else begin
        close_run(lvl, run);
        lvl = obs_pulse;
        run = 1;
      end
      tick();
      guard++;
    end
    if (guard >= 200) chk("busy_timeout", guard, 0);
    if (run > 0) close_run(lvl, run);
    m_done = int'(obs_done);
    m_pend = int'(obs_pulse);
    m_abrt = int'(obs_aborted);
  endtask

  typedef struct {
    logic [1:0] nb;
    int         exp_busy;
    int         exp_lows;
    int         exp_highs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{nb: 2'd2, exp_busy: 13, exp_lows: 2, exp_highs: 1};
    vecs[1] = '{nb: 2'd1, exp_busy: 5,  exp_lows: 1, exp_highs: 0};
    vecs[2] = '{nb: 2'd0, exp_busy: 5,  exp_lows: 1, exp_highs: 0};
    vecs[3] = '{nb: 2'd3, exp_busy: 13, exp_lows: 2, exp_highs: 1};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", int'(busy_m), 0);
    chk("rst_pulse", int'(pulse_m), 1);
    chk("rst_done", int'(done_m), 0);
    chk("rst_aborted", int'(aborted_m), 0);
    $display("[TB] reset: busy=%0d pulse=%0d", busy_m, pulse_m);

    // Table: break-count handling including clamping of 0 and 3
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nb_m = vecs[i].nb;
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      measure();
      chk($sformatf("v%0d_busy", i), m_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_lows", i), m_lows, vecs[i].exp_lows);
      chk($sformatf("v%0d_lmin", i), m_lmin, 5);
      chk($sformatf("v%0d_lmax", i), m_lmax, 5);
      chk($sformatf("v%0d_highs", i), m_highs, vecs[i].exp_highs);
      if (vecs[i].exp_highs > 0) begin
        chk($sformatf("v%0d_hmin", i), m_hmin, 3);
        chk($sformatf("v%0d_hmax", i), m_hmax, 3);
      end
      chk($sformatf("v%0d_done", i), m_done, 1);
      chk($sformatf("v%0d_pulse_end", i), m_pend, 1);
      chk($sformatf("v%0d_aborted", i), m_abrt, 0);
      tick();
      chk($sformatf("v%0d_done_width", i), int'(done_m), 0);
      $display("[TB] vec %0d nb=%0d busy=%0d lows=%0d highs=%0d done=%0d",
               i, vecs[i].nb, m_busy, m_lows, m_highs, m_done);
      tick();
    end

    // Guard time: one break of 5, then 4 high cycles still busy, done on sample 10
    sel = 1'b1;
    nb_g = 2'd1;
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    measure();
    chk("guard_busy", m_busy, 9);
    chk("guard_lows", m_lows, 1);
    chk("guard_lmin", m_lmin, 5);
    chk("guard_highs", m_highs, 1);
    chk("guard_hlen", m_hmax, 4);
    chk("guard_done", m_done, 1);
    chk("guard_pulse_end", m_pend, 1);
    $display("[TB] guard: busy=%0d low=%0d high=%0d done=%0d", m_busy, m_lmin, m_hmax, m_done);
    sel = 1'b0;
    tick();

    // Abort in the second delimiter cycle
    begin
      int dn;
      int bz;
      nb_m = 2'd2;
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      repeat (6) tick();
      chk("abort_pre_pulse", int'(pulse_m), 1);
      chk("abort_pre_busy", int'(busy_m), 1);
      abort_m = 1'b1;
      tick();
      abort_m = 1'b0;
      chk("abort_busy", int'(busy_m), 0);
      chk("abort_pulse", int'(pulse_m), 1);
      chk("abort_strobe", int'(aborted_m), 1);
      chk("abort_done", int'(done_m), 0);
      tick();
      chk("abort_width", int'(aborted_m), 0);
      dn = 0; bz = 0;
      for (int i = 0; i < 20; i++) begin
        if (done_m) dn++;
        if (busy_m) bz++;
        tick();
      end
      chk("abort_no_done", dn, 0);
      chk("abort_stays_idle", bz, 0);
      $display("[TB] abort: aborted strobe seen, later done=%0d busy=%0d", dn, bz);
    end

    // start held through a whole run (n_breaks changed mid-run is not re-latched)
    nb_m = 2'd1;
    start_m = 1'b1;
    tick();
    nb_m = 2'd2;
    measure();
    chk("held_busy", m_busy, 5);
    chk("held_done", m_done, 1);
    tick();
    chk("held_no_restart", int'(busy_m), 0);
    start_m = 1'b0;
    tick();
    chk("held_idle", int'(busy_m), 0);
    $display("[TB] held start: busy=%0d done=%0d restart=%0d", m_busy, m_done, busy_m);

    // start and abort together while idle: nothing starts
    start_m = 1'b1;
    abort_m = 1'b1;
    tick();
    start_m = 1'b0;
    abort_m = 1'b0;
    chk("sa_busy", int'(busy_m), 0);
    chk("sa_pulse", int'(pulse_m), 1);
    chk("sa_aborted", int'(aborted_m), 0);
    tick();
    chk("sa_busy_later", int'(busy_m), 0);
    $display("[TB] start+abort idle: busy=%0d pulse=%0d", busy_m, pulse_m);

    // Reset during the first break, then a fresh full sequence
    nb_m = 2'd2;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (2) tick();
    chk("rstmid_pre_pulse", int'(pulse_m), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_pulse", int'(pulse_m), 1);
    chk("rstmid_busy", int'(busy_m), 0);
    chk("rstmid_done", int'(done_m), 0);
    chk("rstmid_aborted", int'(aborted_m), 0);
    tick();
    chk("rstmid_done2", int'(done_m), 0);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    measure();
    chk("rstmid_busy_run", m_busy, 13);
    chk("rstmid_lows", m_lows, 2);
    chk("rstmid_lmin", m_lmin, 5);
    chk("rstmid_hmin", m_hmin, 3);
    chk("rstmid_run_done", m_done, 1);
    $display("[TB] reset mid-run then restart: busy=%0d lows=%0d done=%0d", m_busy, m_lows, m_done);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
